// File: rtl/jpeg_pkg.sv
// Shared types and byte constants for the JPEG entropy-coded stream writer.
package jpeg_pkg;

    typedef enum logic [2:0] {
        RUN    = 3'd0,
        FLUSH  = 3'd1,
        EOI_FF = 3'd2,
        EOI_D9 = 3'd3,
        DONE   = 3'd4
    } jpeg_state_e;

    localparam logic [7:0] JPEG_STUFF_BYTE = 8'h00;
    localparam logic [7:0] JPEG_MARKER     = 8'hFF;
    localparam logic [7:0] JPEG_EOI        = 8'hD9;

    // 1-padding applied to a final partial byte holding n valid bits
    function automatic logic [7:0] pad_ones(input logic [7:0] top, input logic [2:0] n);
        return top | (8'hFF >> n);
    endfunction

endpackage

// File: rtl/jpeg_bitpacker_if.sv
// Code input and byte output handshakes of the bit packer.
interface jpeg_bitpacker_if;
  logic        inport_valid_i;
  logic [31:0] inport_data_i;
  logic [5:0]  inport_len_i;
  logic        inport_last_i;
  logic        inport_accept_o;
  logic        outport_valid_o;
  logic [7:0]  outport_data_o;
  logic        outport_last_o;
  logic        outport_accept_i;

  modport slave (
    input  inport_valid_i, inport_data_i, inport_len_i, inport_last_i, outport_accept_i,
    output inport_accept_o, outport_valid_o, outport_data_o, outport_last_o
  );

  modport master (
    output inport_valid_i, inport_data_i, inport_len_i, inport_last_i, outport_accept_i,
    input  inport_accept_o, outport_valid_o, outport_data_o, outport_last_o
  );
endinterface

// File: rtl/jpeg_bit_align.sv
// Masks a right-aligned code to its length and places it MSB-first below count filled bits.
module jpeg_bit_align #(
  parameter int BUF_W = 64,
  parameter int CW    = 7
) (
  input  logic [31:0]    code,
  input  logic [5:0]     len,
  input  logic [CW-1:0]  count,
  output logic [5:0]     eff_len,
  output logic [BUF_W-1:0] aligned
);
  logic [5:0]       len_c;
  logic [31:0]      mask_s;
  logic [31:0]      code_m;
  logic [31:0]      left_s;
  logic [BUF_W-1:0] wide_s;

  // illegal lengths above 32 are clamped so the buffer can never overrun
  always_comb begin
    len_c  = (len > 6'd32) ? 6'd32 : len;
    mask_s = (len_c == 6'd32) ? 32'hFFFF_FFFF : ((32'd1 << len_c) - 32'd1);
    code_m = code & mask_s;
    left_s = (len_c == 6'd0) ? 32'd0 : (code_m << (6'd32 - len_c));
    wide_s = {left_s, {(BUF_W-32){1'b0}}} >> count;
  end

  assign eff_len = len_c;
  assign aligned = wide_s;
endmodule

// File: rtl/jpeg_bitpacker.sv
// Packs variable-length codes MSB-first into bytes with 0xFF stuffing, 1-padding and EOI.
module jpeg_bitpacker
  import jpeg_pkg::*;
#(
  parameter int BUF_W = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             img_start_i,
  jpeg_bitpacker_if.slave  bus
);
  localparam int CW = $clog2(BUF_W + 1);
  localparam logic [CW-1:0] ACCEPT_MAX = CW'(BUF_W - 32);
  localparam logic [CW-1:0] BYTE_BITS  = CW'(8);

  jpeg_state_e     state_r;
  logic [BUF_W-1:0] buf_r;
  logic [CW-1:0]   count_r;
  logic            stuff_r;

  logic             out_valid_s;
  logic [7:0]       out_data_s;
  logic             out_last_s;
  logic             accept_s;
  logic             pop_s;
  logic             data_pop_s;
  logic             stuff_pop_s;
  logic             push_s;
  logic [BUF_W-1:0] buf_pop_s;
  logic [CW-1:0]    count_pop_s;
  logic [BUF_W-1:0] aligned_s;
  logic [5:0]       eff_len_s;
  logic [7:0]       top_s;

  assign top_s = buf_r[BUF_W-1 -: 8];

  // output byte selection, decoded purely from registered state
  always_comb begin
    out_valid_s = 1'b0;
    out_data_s  = 8'h00;
    out_last_s  = 1'b0;
    case (state_r)
      RUN: begin
        if (stuff_r) begin
          out_valid_s = 1'b1;
          out_data_s  = JPEG_STUFF_BYTE;
        end else if (count_r >= BYTE_BITS) begin
          out_valid_s = 1'b1;
          out_data_s  = top_s;
        end else begin
          out_valid_s = 1'b0;
        end
      end
      FLUSH: begin
        if (stuff_r) begin
          out_valid_s = 1'b1;
          out_data_s  = JPEG_STUFF_BYTE;
        end else if (count_r >= BYTE_BITS) begin
          out_valid_s = 1'b1;
          out_data_s  = top_s;
        end else if (count_r != '0) begin
          out_valid_s = 1'b1;
          out_data_s  = pad_ones(top_s, count_r[2:0]);
        end else begin
          out_valid_s = 1'b0;
        end
      end
      EOI_FF: begin
        out_valid_s = 1'b1;
        out_data_s  = JPEG_MARKER;
      end
      EOI_D9: begin
        out_valid_s = 1'b1;
        out_data_s  = JPEG_EOI;
        out_last_s  = 1'b1;
      end
      DONE:    out_valid_s = 1'b0;
      default: out_valid_s = 1'b0;
    endcase
  end

  assign accept_s    = (state_r == RUN) && (count_r <= ACCEPT_MAX);
  assign pop_s       = out_valid_s && bus.outport_accept_i;
  assign data_pop_s  = pop_s && !stuff_r && ((state_r == RUN) || (state_r == FLUSH));
  assign stuff_pop_s = pop_s && stuff_r;
  assign push_s      = bus.inport_valid_i && accept_s;

  // pop happens first so the pushed code lands behind the remaining bits
  always_comb begin
    buf_pop_s   = buf_r;
    count_pop_s = count_r;
    if (data_pop_s) begin
      buf_pop_s   = buf_r << 8;
      count_pop_s = (count_r >= BYTE_BITS) ? (count_r - BYTE_BITS) : '0;
    end else begin
      buf_pop_s   = buf_r;
      count_pop_s = count_r;
    end
  end

  jpeg_bit_align #(.BUF_W(BUF_W), .CW(CW)) u_align (
    .code    (bus.inport_data_i),
    .len     (bus.inport_len_i),
    .count   (count_pop_s),
    .eff_len (eff_len_s),
    .aligned (aligned_s)
  );

  // accumulator, stuffing flag and stream state machine
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r <= RUN;
      buf_r   <= '0;
      count_r <= '0;
      stuff_r <= 1'b0;
    end else if (img_start_i) begin
      state_r <= RUN;
      buf_r   <= '0;
      count_r <= '0;
      stuff_r <= 1'b0;
    end else begin
      buf_r   <= buf_pop_s | (push_s ? aligned_s : '0);
      count_r <= count_pop_s + (push_s ? CW'(eff_len_s) : '0);
      if (data_pop_s) begin
        stuff_r <= (out_data_s == JPEG_MARKER);
      end else if (stuff_pop_s) begin
        stuff_r <= 1'b0;
      end else begin
        stuff_r <= stuff_r;
      end
      case (state_r)
        RUN:     if (push_s && bus.inport_last_i) state_r <= FLUSH;
        FLUSH:   if ((count_r == '0) && !stuff_r) state_r <= EOI_FF;
        EOI_FF:  if (pop_s) state_r <= EOI_D9;
        EOI_D9:  if (pop_s) state_r <= DONE;
        DONE:    state_r <= DONE;
        default: state_r <= RUN;
      endcase
    end
  end

  assign bus.inport_accept_o = accept_s;
  assign bus.outport_valid_o = out_valid_s;
  assign bus.outport_data_o  = out_data_s;
  assign bus.outport_last_o  = out_last_s;
endmodule
